// File: rtl/vmul_pkg.sv
// Shared types and constants for the sequential vector multiplier.
package vmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vmul_state_t;

    localparam int VMUL_EW       = 8;
    localparam int VMUL_VLEN_MAX = 16;

endpackage

// File: rtl/vector_mul_seq_multiplier.sv
// Combinational 8x8 signed radix-4 Booth multiplier returning the upper byte
// of the 16-bit product (floor(a*b/256)).
module multiplier (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);

    logic [15:0] a_ext;
    logic [8:0]  b_ext;
    logic [15:0] pp [4];

    assign a_ext = {{8{a_i[7]}}, a_i};
    assign b_ext = {b_i, 1'b0};

    // Each overlapping bit triplet of B selects 0, +-A or +-2A for its digit.
    for (genvar gi = 0; gi < 4; gi++) begin : g_pp
        logic [15:0] sel;
        always_comb begin
            case (b_ext[2*gi +: 3])
                3'b001, 3'b010: sel = a_ext;
                3'b011:         sel = a_ext << 1;
                3'b100:         sel = -(a_ext << 1);
                3'b101, 3'b110: sel = -a_ext;
                default:        sel = '0;
            endcase
        end
        assign pp[gi] = sel << (2*gi);
    end

    assign p_o = 8'((pp[0] + pp[1] + pp[2] + pp[3]) >> 8);

endmodule

// File: rtl/vector_mul_seq.sv
// Sequential vector multiply: one element per cycle through a shared multiplier.
// Optional dot-product accumulator enabled by defining VMUL_DOT_EN.
module vector_mul_seq
    import vmul_pkg::*;
#(
    parameter int VLEN = 8,
    parameter int CW   = $clog2(VLEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VLEN*VMUL_EW-1:0] vec_a,
    input  logic [VLEN*VMUL_EW-1:0] vec_b,
    input  logic [CW-1:0]           vlen_act,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VLEN*VMUL_EW-1:0] vec_out,
    output logic                    busy
`ifdef VMUL_DOT_EN
    ,
    output logic [15:0]             dot_out
`endif
);

    vmul_state_t             state_q, state_d;
    logic [VLEN*VMUL_EW-1:0] a_q, a_d;
    logic [VLEN*VMUL_EW-1:0] b_q, b_d;
    logic [VLEN*VMUL_EW-1:0] res_q, res_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_clamp;
    logic [VMUL_EW-1:0]      mul_a, mul_b, mul_p;
`ifdef VMUL_DOT_EN
    logic [15:0]             acc_q, acc_d;
`endif

    assign cnt_clamp = (vlen_act > CW'(VLEN)) ? CW'(VLEN) : vlen_act;

    // Single shared multiplier fed by the element selected with idx.
    assign mul_a = a_q[idx_q*VMUL_EW +: VMUL_EW];
    assign mul_b = b_q[idx_q*VMUL_EW +: VMUL_EW];

    multiplier u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`ifdef VMUL_DOT_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = vec_a;
                    b_d   = vec_b;
                    cnt_d = cnt_clamp;
                    idx_d = '0;
                    res_d = '0;
`ifdef VMUL_DOT_EN
                    acc_d = '0;
`endif
                    state_d = (cnt_clamp == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                res_d[idx_q*VMUL_EW +: VMUL_EW] = mul_p;
                idx_d = idx_q + CW'(1);
`ifdef VMUL_DOT_EN
                acc_d = acc_q + {{8{mul_p[7]}}, mul_p};
`endif
                if (idx_q == cnt_q - CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
`ifdef VMUL_DOT_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
`ifdef VMUL_DOT_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign vec_out   = res_q;
`ifdef VMUL_DOT_EN
    assign dot_out   = acc_q;
`endif

endmodule

// File: tb/tb_vector_mul_seq.sv
// Directed self-checking bench for vector_mul_seq (VLEN=4); dot_out checks
// are active when VMUL_DOT_EN is defined.
module tb_vector_mul_seq;

    localparam int VLEN = 4;
    localparam int CW   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     vec_a;
    logic [31:0]     vec_b;
    logic [CW-1:0]   vlen_act;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     vec_out;
    logic            busy;
`ifdef VMUL_DOT_EN
    logic [15:0]     dot_out;
`endif

    int checks = 0;
    int errors = 0;

    vector_mul_seq #(.VLEN(VLEN), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .vlen_act  (vlen_act),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vec_out   (vec_out),
        .busy      (busy)
`ifdef VMUL_DOT_EN
        ,
        .dot_out   (dot_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands and let the next edge accept them.
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [CW-1:0] len);
        @(negedge clk);
        vec_a    = a;
        vec_b    = b;
        vlen_act = len;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vec_a    = 32'hDEAD_BEEF;
        vec_b    = 32'hCAFE_F00D;
    endtask

    // Called #1 after the accept edge; latency counts that edge as cycle 1.
    task automatic wait_result(input string tag, input logic [31:0] exp_vec,
                               input logic [15:0] exp_dot, input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("txn %s: latency %0d vec_out %08h", tag, lat, vec_out);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_vec"}, vec_out, exp_vec);
        check({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
`ifdef VMUL_DOT_EN
        check({tag, "_dot"}, {16'd0, dot_out}, {16'd0, exp_dot});
`else
        if (exp_dot === 16'hxxxx) $display("txn %s: no dot", tag);
`endif
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_inrdy"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_ovld"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vec_a     = '0;
        vec_b     = '0;
        vlen_act  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_inrdy", {31'd0, in_ready}, 32'd1);
        check("rst_ovld", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_vec", vec_out, 32'd0);
`ifdef VMUL_DOT_EN
        check("rst_dot", {16'd0, dot_out}, 32'd0);
`endif
        rst = 1'b0;

        // Full length: 40*40, 7F*7F, 80*80, FF*01.
        accept(32'hFF80_7F40, 32'h0180_7F40, 3'd4);
        wait_result("full4", 32'hFF40_3F10, 16'h008E, 5);
        release_out("full4");

        // Two elements; upper operand bytes must not leak into the result.
        accept(32'h3412_8080, 32'h5678_807F, 3'd2);
        wait_result("len2", 32'h0000_40C0, 16'h0000, 3);
        release_out("len2");

        // Zero length clears the previous result.
        accept(32'h1111_1111, 32'h2222_2222, 3'd0);
        wait_result("len0", 32'h0000_0000, 16'h0000, 1);
        release_out("len0");

        // Length 7 clamps to 4 elements.
        accept(32'h10FE_0302, 32'h1040_4080, 3'd7);
        wait_result("clamp7", 32'h01FF_00FF, 16'hFFFF, 5);
        release_out("clamp7");

        // Negative times negative and mixed signs over three elements.
        accept(32'h000A_81FF, 32'h00F6_81FF, 3'd3);
        wait_result("len3", 32'h00FF_3F00, 16'h003E, 4);
        release_out("len3");

        // Backpressure: hold DONE with a pending input waiting upstream.
        accept(32'hFF80_7F40, 32'h0180_7F40, 3'd4);
        wait_result("bp", 32'hFF40_3F10, 16'h008E, 5);
        @(negedge clk);
        vec_a    = 32'h3412_8080;
        vec_b    = 32'h5678_807F;
        vlen_act = 3'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_ovld", {31'd0, out_valid}, 32'd1);
            check("bp_hold_vec", vec_out, 32'hFF40_3F10);
            check("bp_hold_inrdy", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_idle_inrdy", {31'd0, in_ready}, 32'd1);
        check("bp_idle_ovld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_busy", {31'd0, busy}, 32'd1);
        wait_result("bp_next", 32'h0000_40C0, 16'h0000, 3);
        release_out("bp_next");

        // Reset during the second RUN cycle aborts the operation.
        accept(32'hFF80_7F40, 32'h0180_7F40, 3'd4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_inrdy", {31'd0, in_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_vec", vec_out, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            check("abort_no_ovld", 32'(seen), 32'd0);
        end
        accept(32'h000A_81FF, 32'h00F6_81FF, 3'd3);
        wait_result("after_abort", 32'h00FF_3F00, 16'h003E, 4);
        release_out("after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
